// File: rtl/axi_stream_remove_header.sv
// ---------------------------------------------------------------------------
// axi_stream_remove_header
//
// Strips a commanded number of leading bytes (R = byte_remove_cnt + 1, in the
// range 1..DATA_BYTE_WD) from each AXI-Stream packet and re-packs what is
// left MSB-aligned on the output. Packets holding R bytes or fewer are
// discarded and reported with a single-cycle drop_pkt pulse.
//
// Byte order is MSB-first: data[DATA_WD-1 -: 8] / keep[DATA_BYTE_WD-1] is the
// first byte of a beat.
//
// Ports
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   valid_in/ready_in, data_in, keep_in, last_in
//                    input stream; keep_in is all ones except on the last
//                    beat, where it is contiguous from the MSB
//   valid_out/ready_out, data_out, keep_out, last_out
//                    registered output stream; bytes with keep_out=0 are 0
//   valid_remove/ready_remove, byte_remove_cnt
//                    per-packet remove command, accepted only between packets
//   drop_pkt         one-cycle pulse when a too-short packet is discarded
// ---------------------------------------------------------------------------
module axi_stream_remove_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,

  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,

  input  logic                    valid_remove,
  input  logic [BYTE_CNT_WD-1:0]  byte_remove_cnt,
  output logic                    ready_remove,

  output logic                    drop_pkt
);

  // Byte counts need one extra bit so that a full beat (W bytes) fits.
  localparam int               CNT_W = BYTE_CNT_WD + 1;
  localparam logic [CNT_W-1:0] W_C   = CNT_W'(DATA_BYTE_WD);

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    STREAM,
    FLUSH
  } state_t;

  state_t                  state;
  state_t                  state_nxt;

  logic [CNT_W-1:0]        r_q;          // bytes removed from this packet
  logic [DATA_WD-1:0]      resid_q;      // previous beat; its low W-R bytes are the residual
  logic [CNT_W-1:0]        flush_len_q;  // bytes left for the FLUSH beat
  logic                    ready_remove_q;

  logic                    out_free;
  logic                    in_fire;
  logic                    cmd_fire;
  logic [CNT_W-1:0]        in_len;

  logic                    load;
  logic [DATA_WD-1:0]      nxt_data;
  logic [DATA_BYTE_WD-1:0] nxt_keep;
  logic                    nxt_last;
  logic                    drop_nxt;

  // Concatenate two beats and return the W bytes starting at byte 'skip'.
  // With lo = 0 this just moves bytes skip.. of hi up to the MSB.
  function automatic logic [DATA_WD-1:0] pack(
    input logic [DATA_WD-1:0] hi,
    input logic [DATA_WD-1:0] lo,
    input logic [CNT_W-1:0]   skip
  );
    logic [2*DATA_WD-1:0] cat;
    cat = {hi, lo} << {skip, 3'b000};
    return cat[2*DATA_WD-1 -: DATA_WD];
  endfunction

  // Keep vector with n contiguous ones starting at the MSB.
  function automatic logic [DATA_BYTE_WD-1:0] keep_of(input logic [CNT_W-1:0] n);
    logic [DATA_BYTE_WD-1:0] k;
    k = '0;
    for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
      k[DATA_BYTE_WD-1-i] = (CNT_W'(i) < n);
    end
    return k;
  endfunction

  // Expand a keep vector to a bit mask over the data bus.
  function automatic logic [DATA_WD-1:0] mask_of(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
      m[8*i +: 8] = {8{k[i]}};
    end
    return m;
  endfunction

  always_comb begin
    in_len = '0;
    for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
      in_len = in_len + CNT_W'(keep_in[i]);
    end
  end

  assign out_free     = !valid_out || ready_out;
  assign ready_in     = ((state == FIRST) || (state == STREAM)) && out_free;
  assign ready_remove = ready_remove_q;
  assign in_fire      = valid_in && ready_in;
  assign cmd_fire     = valid_remove && ready_remove_q;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and next output beat
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    nxt_data  = '0;
    nxt_keep  = '0;
    nxt_last  = 1'b0;
    drop_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_fire) begin
          state_nxt = FIRST;
        end
      end

      // Beat 0 only feeds the residual unless the packet ends right here.
      FIRST: begin
        if (in_fire) begin
          if (last_in) begin
            state_nxt = IDLE;
            if (in_len > r_q) begin
              load     = 1'b1;
              nxt_data = pack(data_in, '0, r_q);
              nxt_keep = keep_of(in_len - r_q);
              nxt_last = 1'b1;
            end else begin
              drop_nxt = 1'b1;
            end
          end else begin
            state_nxt = STREAM;
          end
        end
      end

      STREAM: begin
        if (in_fire) begin
          load     = 1'b1;
          nxt_data = pack(resid_q, data_in, r_q);
          nxt_keep = '1;
          if (last_in) begin
            if (in_len <= r_q) begin
              // Residual plus every byte of the last beat fit in one beat.
              nxt_keep  = keep_of(W_C - r_q + in_len);
              nxt_last  = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = FLUSH;
            end
          end
        end
      end

      FLUSH: begin
        if (out_free) begin
          load      = 1'b1;
          nxt_data  = pack(resid_q, '0, r_q);
          nxt_keep  = keep_of(flush_len_q);
          nxt_last  = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase

    // Bytes outside keep are always driven as zero.
    nxt_data = nxt_data & mask_of(nxt_keep);
  end

  // -------------------------------------------------------------------------
  // Datapath and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q            <= '0;
      resid_q        <= '0;
      flush_len_q    <= '0;
      ready_remove_q <= 1'b0;
      drop_pkt       <= 1'b0;
      valid_out      <= 1'b0;
      data_out       <= '0;
      keep_out       <= '0;
      last_out       <= 1'b0;
    end else begin
      if (cmd_fire) begin
        r_q <= CNT_W'(byte_remove_cnt) + CNT_W'(1);
      end

      if (in_fire) begin
        resid_q <= data_in;
        if (last_in) begin
          flush_len_q <= in_len - r_q;
        end
      end

      // Registered so that the command port is closed during reset and
      // reopens in the first cycle spent in IDLE.
      ready_remove_q <= (state_nxt == IDLE);
      drop_pkt       <= drop_nxt;

      if (load) begin
        valid_out <= 1'b1;
        data_out  <= nxt_data;
        keep_out  <= nxt_keep;
        last_out  <= nxt_last;
      end else if (ready_out) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_stream_remove_header.sv
module tb_axi_stream_remove_header;

  localparam int DW = 32;
  localparam int W  = 4;

  typedef logic [7:0] u8_t;
  typedef u8_t bq_t[$];
  typedef struct {
    logic [DW-1:0] d;
    logic [W-1:0]  k;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [W-1:0]  keep_in = '0;
  logic          last_in = 1'b0;
  logic          ready_in;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic [W-1:0]  keep_out;
  logic          last_out;
  logic          ready_out = 1'b1;
  logic          valid_remove = 1'b0;
  logic [1:0]    byte_remove_cnt = '0;
  logic          ready_remove;
  logic          drop_pkt;

  axi_stream_remove_header #(
    .DATA_WD(DW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_in       (valid_in),
    .data_in        (data_in),
    .keep_in        (keep_in),
    .last_in        (last_in),
    .ready_in       (ready_in),
    .valid_out      (valid_out),
    .data_out       (data_out),
    .keep_out       (keep_out),
    .last_out       (last_out),
    .ready_out      (ready_out),
    .valid_remove   (valid_remove),
    .byte_remove_cnt(byte_remove_cnt),
    .ready_remove   (ready_remove),
    .drop_pkt       (drop_pkt)
  );

  always #5 clk = ~clk;

  beat_t exp_q[$];
  int    checks     = 0;
  int    failures   = 0;
  int    exp_drops  = 0;
  int    drops_seen = 0;
  bit    mon_en     = 1'b0;
  bit    rnd_ready  = 1'b0;

  // Downstream ready: changed just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ready_out = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: compares every accepted output beat against the scoreboard and
  // checks that a stalled beat does not change.
  initial begin
    bit            stall_pending;
    logic [DW-1:0] sd;
    logic [W-1:0]  sk;
    logic          sl;
    beat_t         e;
    stall_pending = 1'b0;
    sd = '0;
    sk = '0;
    sl = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && mon_en) begin
        if (stall_pending) begin
          checks++;
          if (!(valid_out && data_out == sd && keep_out == sk && last_out == sl)) begin
            failures++;
            $display("FAIL stall_stable: got v=%b d=%h k=%b l=%b required v=1 d=%h k=%b l=%b",
                     valid_out, data_out, keep_out, last_out, sd, sk, sl);
          end
        end
        if (valid_out && ready_out) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL out_beat: got unexpected d=%h k=%b l=%b required no beat",
                     data_out, keep_out, last_out);
          end else begin
            e = exp_q.pop_front();
            if (data_out !== e.d || keep_out !== e.k || last_out !== e.l) begin
              failures++;
              $display("FAIL out_beat: got d=%h k=%b l=%b required d=%h k=%b l=%b",
                       data_out, keep_out, last_out, e.d, e.k, e.l);
            end
          end
        end
        stall_pending = valid_out && !ready_out;
        sd = data_out;
        sk = keep_out;
        sl = last_out;
        if (drop_pkt) drops_seen++;
      end else begin
        stall_pending = 1'b0;
      end
    end
  end

  task automatic put_cmd(input int r);
    bit hs;
    int n;
    valid_remove    = 1'b1;
    byte_remove_cnt = 2'(r - 1);
    hs = 1'b0;
    n  = 0;
    while (!hs) begin
      @(negedge clk);
      hs = ready_remove;
      @(posedge clk);
      #1;
      n++;
      if (!hs && n > 2000) begin
        $display("FAIL cmd_timeout: got no ready_remove required handshake");
        $fatal(1);
      end
    end
    valid_remove = 1'b0;
  endtask

  task automatic put_beat(input logic [DW-1:0] d, input logic [W-1:0] k, input logic l);
    bit hs;
    int n;
    valid_in = 1'b1;
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    hs = 1'b0;
    n  = 0;
    while (!hs) begin
      @(negedge clk);
      hs = ready_in;
      @(posedge clk);
      #1;
      n++;
      if (!hs && n > 2000) begin
        $display("FAIL beat_timeout: got no ready_in required handshake");
        $fatal(1);
      end
    end
    valid_in = 1'b0;
    data_in  = $urandom;
    keep_in  = 4'($urandom);
    last_in  = 1'($urandom);
  endtask

  // Reference: the output byte stream is the packet minus its first r bytes,
  // cut into W-byte beats; a packet of r bytes or fewer is dropped.
  task automatic expect_pkt(input int r, input bq_t q);
    int    n;
    beat_t b;
    n = q.size();
    if (n <= r) begin
      exp_drops++;
    end else begin
      for (int i = r; i < n; i += W) begin
        b.d = '0;
        b.k = '0;
        for (int j = 0; j < W; j++) begin
          if (i + j < n) begin
            b.d[DW-1-8*j -: 8] = q[i+j];
            b.k[W-1-j] = 1'b1;
          end
        end
        b.l = (i + W >= n);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic drive_pkt(input int r, input bq_t q, input bit gaps, input bit chk_flush);
    int            n;
    logic [DW-1:0] d;
    logic [W-1:0]  k;
    n = q.size();
    put_cmd(r);
    for (int i = 0; i < n; i += W) begin
      d = $urandom;
      k = '0;
      for (int j = 0; j < W; j++) begin
        if (i + j < n) begin
          d[DW-1-8*j -: 8] = q[i+j];
          k[W-1-j] = 1'b1;
        end
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      put_beat(d, k, (i + W >= n));
    end
    if (chk_flush) begin
      @(negedge clk);
      checks++;
      if (ready_in !== 1'b0) begin
        failures++;
        $display("FAIL flush_ready_in: got %b required 0", ready_in);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pkt(input int r, input bq_t q, input bit gaps, input bit chk_flush);
    expect_pkt(r, q);
    drive_pkt(r, q, gaps, chk_flush);
  endtask

  // Directed bytes A0 A1 A2 A3 B0 B1 ...
  function automatic bq_t mk_seq(input int n);
    bq_t q;
    for (int k = 0; k < n; k++) q.push_back({4'(10 + k / 4), 4'(k % 4)});
    return q;
  endfunction

  function automatic bq_t mk_rand(input int n);
    bq_t q;
    for (int k = 0; k < n; k++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d beats outstanding required 0", exp_q.size());
    end
  endtask

  initial begin
    bq_t q;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({valid_out, data_out, keep_out, last_out, ready_in, ready_remove, drop_pkt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b d=%h k=%b l=%b ri=%b rr=%b dp=%b required all 0",
               valid_out, data_out, keep_out, last_out, ready_in, ready_remove, drop_pkt);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_remove !== 1'b1) begin
      failures++;
      $display("FAIL idle_ready_remove: got %b required 1", ready_remove);
    end
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Directed cases
    send_pkt(2, mk_seq(10), 1'b0, 1'b0);
    send_pkt(2, mk_seq(11), 1'b0, 1'b1);
    send_pkt(4, mk_seq(13), 1'b0, 1'b0);
    send_pkt(3, mk_seq(2), 1'b0, 1'b0);
    send_pkt(3, mk_seq(4), 1'b0, 1'b0);
    send_pkt(4, mk_seq(4), 1'b0, 1'b0);
    send_pkt(1, mk_seq(5), 1'b0, 1'b0);
    drain();

    // Randomized traffic with gaps and back-pressure
    rnd_ready = 1'b1;
    for (int p = 0; p < 200; p++) begin
      send_pkt($urandom_range(1, W), mk_rand($urandom_range(1, 14)), 1'b1, 1'b0);
    end
    drain();

    // Reset in the middle of a packet
    rnd_ready = 1'b0;
    mon_en    = 1'b0;
    put_cmd(2);
    q = mk_rand(12);
    for (int i = 0; i < 3; i++) begin
      put_beat({q[4*i], q[4*i+1], q[4*i+2], q[4*i+3]}, 4'b1111, 1'b0);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({valid_out, data_out, keep_out, last_out, ready_in, ready_remove, drop_pkt} !== '0) begin
      failures++;
      $display("FAIL async_reset: got v=%b d=%h k=%b l=%b ri=%b rr=%b dp=%b required all 0",
               valid_out, data_out, keep_out, last_out, ready_in, ready_remove, drop_pkt);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    send_pkt(2, mk_seq(11), 1'b0, 1'b0);
    rnd_ready = 1'b1;
    send_pkt(1, mk_rand(9), 1'b1, 1'b0);
    drain();

    checks++;
    if (drops_seen != exp_drops) begin
      failures++;
      $display("FAIL drop_count: got %0d required %0d", drops_seen, exp_drops);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
